alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arb_pkg.sv | 24 ++
 rtl/alu_core.sv | 52 +++++
 rtl/alu_arbiter.sv | 111 +++++++++++
 tb/tb_alu_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared widths, opcode constants and FSM encoding for the ALU arbiter.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_arb_pkg;

  localparam int DATA_W = 8;
  localparam int OPND_W = 4;

  localparam logic [2:0] OP_INC     = 3'b000;
  localparam logic [2:0] OP_ADD_RCA = 3'b001;
  localparam logic [2:0] OP_ADD     = 3'b010;
  localparam logic [2:0] OP_ORXOR   = 3'b011;
  localparam logic [2:0] OP_NZ      = 3'b100;
  localparam logic [2:0] OP_SHL     = 3'b101;
  localparam logic [2:0] OP_SHR     = 3'b110;
  localparam logic [2:0] OP_MUL     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: 4-bit operand A against 8-bit accumulator B, 8-bit result.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result follows the inputs. Macro ALU_ARBITER_MUL_EN adds the multiplier.
module alu_core
  import alu_arb_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [OPND_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  logic [OPND_W:0]   carry;
  logic [OPND_W-1:0] sum_rca;
  logic [OPND_W:0]   sum_beh;
  logic [OPND_W:0]   inc_sum;
  logic [DATA_W-1:0] mul_res;

  // Gate-level ripple-carry adder; must match the behavioural adder bit for bit.
  assign carry[0] = 1'b0;
  for (genvar i = 0; i < OPND_W; i++) begin : g_rca
    assign sum_rca[i]   = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign sum_beh = {1'b0, a} + {1'b0, b[OPND_W-1:0]};
  assign inc_sum = {1'b0, a} + 5'd1;

`ifdef ALU_ARBITER_MUL_EN
  // Only the low byte of the product is ever used, so an 8x8 multiply suffices.
  assign mul_res = {4'b0000, a} * b;
`else
  assign mul_res = '0;
`endif

  // Opcode decode; shifts by 8 or more clear the result.
  always_comb begin
    result = '0;
    case (op)
      OP_INC:     result = {3'b000, inc_sum};
      OP_ADD_RCA: result = {3'b000, carry[OPND_W], sum_rca};
      OP_ADD:     result = {3'b000, sum_beh};
      OP_ORXOR:   result = {a | b[OPND_W-1:0], a ^ b[OPND_W-1:0]};
      OP_NZ:      result = {7'b0000000, (|a) | (|b[OPND_W-1:0])};
      OP_SHL:     result = a[3] ? '0 : (b << a[2:0]);
      OP_SHR:     result = a[3] ? '0 : (b >> a[2:0]);
      OP_MUL:     result = mul_res;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end to a shared ALU with per-requester accumulators.
// Latency: accept edge -> EXEC -> RESP; rsp_valid rises on the edge after the accept edge, 3 cycles/op.
// Backpressure: rsp_valid holds with stable data until rsp_ready; requesters wait with valid held.
// Macro ALU_ARBITER_MUL_EN enables opcode 111 multiply (otherwise it returns 8'h00).
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter logic [DATA_W-1:0] ACC_RST = 8'h00
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_op,
  input  logic [OPND_W-1:0] req0_a,
  input  logic              req0_clr,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_op,
  input  logic [OPND_W-1:0] req1_a,
  input  logic              req1_clr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic [DATA_W-1:0] acc0,
  output logic [DATA_W-1:0] acc1,
  output logic              busy
);

  state_t            state;
  logic              prio;      // requester favoured when both are valid
  logic              grant;
  logic              accept;
  logic [2:0]        op_q;
  logic [OPND_W-1:0] a_q;
  logic              clr_q;
  logic              id_q;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_res;

  // Round-robin pick: a lone requester wins, a tie goes to the favoured one.
  always_comb begin
    grant = prio;
    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = (state == ST_IDLE) && req0_valid && !grant;
  assign req1_ready = (state == ST_IDLE) && req1_valid &&  grant;
  assign accept     = req0_ready || req1_ready;
  assign rsp_valid  = (state == ST_RESP);
  assign busy       = (state != ST_IDLE);
  assign alu_b      = id_q ? acc1 : acc0;

  alu_core u_alu_core (
    .op     (op_q),
    .a      (a_q),
    .b      (alu_b),
    .result (alu_res)
  );

  // Control FSM: latch the winner, execute for one cycle, hold the response until taken.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      prio     <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      clr_q    <= 1'b0;
      id_q     <= 1'b0;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      acc0     <= ACC_RST;
      acc1     <= ACC_RST;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q  <= grant ? req1_op  : req0_op;
            a_q   <= grant ? req1_a   : req0_a;
            clr_q <= grant ? req1_clr : req0_clr;
            id_q  <= grant;
            prio  <= ~grant;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data <= alu_res;
          rsp_id   <= id_q;
          if (id_q) begin
            acc1 <= clr_q ? '0 : alu_res;
          end else begin
            acc0 <= clr_q ? '0 : alu_res;
          end
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with ACC_RST = 8'h81.
// Inputs change on the falling edge; outputs are sampled on or just after it.
// Expected values are hand-computed; opcode 111 expectation follows ALU_ARBITER_MUL_EN.
module tb_alu_arbiter;

  logic       clock = 1'b0;
  logic       resetn;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [2:0] req0_op, req1_op;
  logic [3:0] req0_a, req1_a;
  logic       req0_clr, req1_clr;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_data, acc0, acc1;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;

`ifdef ALU_ARBITER_MUL_EN
  localparam logic [7:0] MUL_EXP = 8'h0F;
`else
  localparam logic [7:0] MUL_EXP = 8'h00;
`endif

  typedef struct packed {
    logic       id;
    logic [2:0] op;
    logic [3:0] a;
    logic       clr;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [16];

  always #5 clock = ~clock;

  alu_arbiter #(.ACC_RST(8'h81)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_clr   (req0_clr),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_clr   (req1_clr),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .acc0       (acc0),
    .acc1       (acc1),
    .busy       (busy)
  );

  task automatic do_reset();
    @(negedge clock);
    resetn     = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
  endtask

  // Bounded wait for the given requester's ready; a timeout is a failed comparison.
  task automatic wait_ready(input logic id, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (id ? req1_ready : req0_ready) begin
        ok = 1'b1;
        return;
      end
      @(negedge clock);
    end
    vectors++;
    miscompares++;
    $display("FAIL wait_ready%0d: ready never seen within 20 cycles, required ready=1", id);
  endtask

  // Issue one operation with rsp_ready high and return the response fields.
  task automatic run_op(input logic id, input logic [2:0] op, input logic [3:0] a,
                        input logic clr, output logic [7:0] d, output logic rid);
    logic ok;
    logic got;
    d   = 8'hxx;
    rid = 1'bx;
    rsp_ready = 1'b1;
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_clr = clr;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_clr = clr;
    end
    wait_ready(id, ok);
    if (ok) @(negedge clock);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (!ok) return;
    got = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL rsp_wait: rsp_valid never seen within 10 cycles, required rsp_valid=1");
      return;
    end
    d   = rsp_data;
    rid = rsp_id;
    @(negedge clock);
  endtask

  task automatic test_reset();
    resetn     = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = '0; req1_op = '0; req0_a = '0; req1_a = '0;
    req0_clr = 1'b0; req1_clr = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clock);
    vectors++;
    if ({rsp_valid, rsp_id, busy, req0_ready, req1_ready, rsp_data, acc0, acc1} !==
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h81, 8'h81}) begin
      miscompares++;
      $display("FAIL reset_state: got vld=%b id=%b busy=%b rdy=%b%b data=%h acc0=%h acc1=%h, required 0 0 0 00 00 81 81",
               rsp_valid, rsp_id, busy, req0_ready, req1_ready, rsp_data, acc0, acc1);
    end
    resetn = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_shift();
    logic [7:0] d;
    logic       rid;
    do_reset();
    run_op(1'b0, 3'b101, 4'h9, 1'b0, d, rid);
    vectors++;
    if (d !== 8'h00 || acc0 !== 8'h00) begin
      miscompares++;
      $display("FAIL shl_by_9: got data=%h acc0=%h, required 00 00", d, acc0);
    end
    do_reset();
    run_op(1'b0, 3'b110, 4'h1, 1'b1, d, rid);
    vectors++;
    if (d !== 8'h40 || acc0 !== 8'h00 || acc1 !== 8'h81) begin
      miscompares++;
      $display("FAIL shr_clr: got data=%h acc0=%h acc1=%h, required 40 00 81", d, acc0, acc1);
    end
  endtask

  task automatic test_basic();
    logic [7:0] d;
    logic       rid;
    do_reset();
    run_op(1'b0, 3'b000, 4'hF, 1'b0, d, rid);
    vectors++;
    if (d !== 8'h10 || rid !== 1'b0 || acc0 !== 8'h10 || acc1 !== 8'h81) begin
      miscompares++;
      $display("FAIL inc_f: got data=%h id=%b acc0=%h acc1=%h, required 10 0 10 81", d, rid, acc0, acc1);
    end
  endtask

  // Starts from acc0=10, acc1=81 left by test_basic.
  task automatic test_alu();
    logic [7:0] d, e0, e1;
    logic       rid;
    tbl[0]  = '{1'b0, 3'b001, 4'h3, 1'b0, 8'h03};
    tbl[1]  = '{1'b0, 3'b010, 4'hE, 1'b0, 8'h11};
    tbl[2]  = '{1'b0, 3'b001, 4'hF, 1'b0, 8'h10};
    tbl[3]  = '{1'b0, 3'b011, 4'h5, 1'b0, 8'h55};
    tbl[4]  = '{1'b0, 3'b011, 4'h3, 1'b0, 8'h76};
    tbl[5]  = '{1'b0, 3'b100, 4'h0, 1'b0, 8'h01};
    tbl[6]  = '{1'b0, 3'b000, 4'h0, 1'b1, 8'h01};
    tbl[7]  = '{1'b0, 3'b100, 4'h0, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, 3'b000, 4'hE, 1'b0, 8'h0F};
    tbl[9]  = '{1'b0, 3'b001, 4'hF, 1'b0, 8'h1E};
    tbl[10] = '{1'b0, 3'b010, 4'hF, 1'b0, 8'h1D};
    tbl[11] = '{1'b1, 3'b110, 4'h7, 1'b0, 8'h01};
    tbl[12] = '{1'b1, 3'b101, 4'h7, 1'b0, 8'h80};
    tbl[13] = '{1'b1, 3'b101, 4'h8, 1'b0, 8'h00};
    tbl[14] = '{1'b1, 3'b000, 4'h2, 1'b0, 8'h03};
    tbl[15] = '{1'b1, 3'b111, 4'h5, 1'b0, MUL_EXP};
    e0 = 8'h10;
    e1 = 8'h81;
    for (int i = 0; i < 16; i++) begin
      run_op(tbl[i].id, tbl[i].op, tbl[i].a, tbl[i].clr, d, rid);
      vectors++;
      if (d !== tbl[i].exp || rid !== tbl[i].id) begin
        miscompares++;
        $display("FAIL alu_vec%0d: got data=%h id=%b, required %h %b", i, d, rid, tbl[i].exp, tbl[i].id);
      end
      if (tbl[i].id) e1 = tbl[i].clr ? 8'h00 : tbl[i].exp;
      else           e0 = tbl[i].clr ? 8'h00 : tbl[i].exp;
      vectors++;
      if (acc0 !== e0 || acc1 !== e1) begin
        miscompares++;
        $display("FAIL acc_vec%0d: got acc0=%h acc1=%h, required %h %h", i, acc0, acc1, e0, e1);
      end
    end
  endtask

  task automatic test_round_robin();
    logic seen;
    logic exp_id;
    do_reset();
    rsp_ready  = 1'b1;
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 4'h1; req0_clr = 1'b0;
    req1_valid = 1'b1; req1_op = 3'b000; req1_a = 4'h2; req1_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_id = (i % 2 == 1);
      seen = 1'b0;
      for (int n = 0; n < 20; n++) begin
        #1;
        if (req0_ready || req1_ready) begin
          seen = 1'b1;
          break;
        end
        @(negedge clock);
      end
      vectors++;
      if (!seen || (req0_ready && req1_ready) || req1_ready !== exp_id) begin
        miscompares++;
        $display("FAIL rr_grant%0d: got ready0=%b ready1=%b, required grant to %0d only",
                 i, req0_ready, req1_ready, exp_id);
      end
      @(negedge clock);
      @(negedge clock);
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_id !== exp_id) begin
        miscompares++;
        $display("FAIL rr_rsp%0d: got vld=%b id=%b, required 1 %0d", i, rsp_valid, rsp_id, exp_id);
      end
      @(negedge clock);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_stall();
    logic ok;
    do_reset();
    rsp_ready  = 1'b0;
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 4'h7; req0_clr = 1'b0;
    wait_ready(1'b0, ok);
    if (!ok) begin
      req0_valid = 1'b0;
      return;
    end
    @(negedge clock);
    req0_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lat_exec: got busy=%b vld=%b, required 1 0", busy, rsp_valid);
    end
    @(negedge clock);
    req0_valid = 1'b1;
    req1_valid = 1'b1; req1_op = 3'b000; req1_a = 4'h1; req1_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if ({rsp_valid, rsp_id, busy, req0_ready, req1_ready, rsp_data} !==
          {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h08}) begin
        miscompares++;
        $display("FAIL stall%0d: got vld=%b id=%b busy=%b rdy=%b%b data=%h, required 1 0 1 00 08",
                 i, rsp_valid, rsp_id, busy, req0_ready, req1_ready, rsp_data);
      end
      @(negedge clock);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    @(negedge clock);
    vectors++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || acc0 !== 8'h08) begin
      miscompares++;
      $display("FAIL stall_release: got vld=%b busy=%b acc0=%h, required 0 0 08", rsp_valid, busy, acc0);
    end
  endtask

  // Starts from acc0=08 left by test_stall.
  task automatic test_reset_mid();
    logic ok;
    rsp_ready  = 1'b1;
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 4'h3; req0_clr = 1'b0;
    wait_ready(1'b0, ok);
    if (ok) @(negedge clock);
    req0_valid = 1'b0;
    if (!ok) return;
    resetn = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || acc0 !== 8'h81 || acc1 !== 8'h81) begin
      miscompares++;
      $display("FAIL reset_mid: got busy=%b vld=%b acc0=%h acc1=%h, required 0 0 81 81",
               busy, rsp_valid, acc0, acc1);
    end
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      vectors++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || acc0 !== 8'h81) begin
        miscompares++;
        $display("FAIL reset_mid_after%0d: got vld=%b busy=%b acc0=%h, required 0 0 81",
                 i, rsp_valid, busy, acc0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_shift();
    test_basic();
    test_alu();
    test_round_robin();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
